// File: rtl/vie_mem_stage_if.sv
// Execute-to-memory handshake bundle for vie_mem_stage.
// Carries es_rt_value only when VIE_MS_LWLR_EN is defined.
interface vie_mem_stage_if;
    logic [129:0] esbus_i;
    logic         es_to_ms_valid;
    logic         ms_allowin;
`ifdef VIE_MS_LWLR_EN
    logic [31:0]  es_rt_value;

    modport master (
        output esbus_i,
        output es_to_ms_valid,
        output es_rt_value,
        input  ms_allowin
    );
    modport slave (
        input  esbus_i,
        input  es_to_ms_valid,
        input  es_rt_value,
        output ms_allowin
    );
`else
    modport master (
        output esbus_i,
        output es_to_ms_valid,
        input  ms_allowin
    );
    modport slave (
        input  esbus_i,
        input  es_to_ms_valid,
        output ms_allowin
    );
`endif
endinterface

// File: rtl/vie_mem_stage.sv
// MIPS memory-access stage: registers the execute bus, aligns load data.
// Define VIE_MS_LWLR_EN to add LWL/LWR merging with es_rt_value.
module vie_mem_stage (
    input  logic                  clock,
    input  logic                  reset,
    vie_mem_stage_if.slave        es,
    input  logic [31:0]           data_sram_rdata,
    input  logic                  ws_allowin,
    input  logic                  flush_i,
    output logic [126:0]          msbus_o,
    output logic [37:0]           msfwd_o
);

    typedef struct packed {
        logic [31:0] baddr;
        logic        bd;
        logic [7:0]  op;
        logic [7:0]  cp0_addr;
        logic [5:0]  exc;
        logic [6:0]  dest;
        logic [31:0] pc;
        logic [31:0] res;
    } ms_pl_t;

    logic        ms_valid_r;
    logic [2:0]  ld_type_r;
    ms_pl_t      pl_r;
    logic [31:0] rdata_buf;
    logic        buf_vld;
    logic        ms_cango;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic        es_hs;
    logic [31:0] rd;
    logic [31:0] rd_sh;
    logic [15:0] half;
    logic [1:0]  off;
    logic [31:0] ld_data;
    logic        fwd_we;
    logic        unused_es_vld;

    assign unused_es_vld = es.esbus_i[129];

`ifdef VIE_MS_LWLR_EN
    logic [31:0] rt_r;
`endif

    assign ms_cango       = 1'b1;
    assign ms_allowin     = !ms_valid_r || ws_allowin;
    assign ms_to_ws_valid = ms_valid_r & ms_cango;
    assign es.ms_allowin  = ms_allowin;
    assign es_hs          = es.es_to_ms_valid && ms_allowin;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ms_valid_r <= 1'b0;
            ld_type_r  <= 3'd0;
            pl_r       <= '0;
            rdata_buf  <= 32'd0;
            buf_vld    <= 1'b0;
`ifdef VIE_MS_LWLR_EN
            rt_r       <= 32'd0;
`endif
        end else begin
            if (flush_i)
                ms_valid_r <= 1'b0;
            else if (ms_allowin)
                ms_valid_r <= es.es_to_ms_valid;

            if (es_hs) begin
                ld_type_r <= es.esbus_i[128:126];
                pl_r      <= es.esbus_i[125:0];
`ifdef VIE_MS_LWLR_EN
                rt_r      <= es.es_rt_value;
`endif
            end

            // SRAM data is only valid in the first MEM cycle; hold it across a stall
            if (flush_i || (ms_valid_r && ws_allowin)) begin
                buf_vld <= 1'b0;
            end else if (ms_valid_r && ld_type_r != 3'd0 &&
                         !buf_vld && !ws_allowin) begin
                buf_vld   <= 1'b1;
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    always_comb begin
        rd      = buf_vld ? rdata_buf : data_sram_rdata;
        off     = pl_r.res[1:0];
        rd_sh   = rd >> {off, 3'b000};
        half    = off[1] ? rd[31:16] : rd[15:0];
        ld_data = rd;
        unique case (ld_type_r)
            3'd0: ld_data = pl_r.res;
            3'd1: ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'd2: ld_data = {24'd0, rd_sh[7:0]};
            3'd3: ld_data = {{16{half[15]}}, half};
            3'd4: ld_data = {16'd0, half};
`ifdef VIE_MS_LWLR_EN
            3'd6: begin
                unique case (off)
                    2'd0: ld_data = {rd[7:0], rt_r[23:0]};
                    2'd1: ld_data = {rd[15:0], rt_r[15:0]};
                    2'd2: ld_data = {rd[23:0], rt_r[7:0]};
                    default: ld_data = rd;
                endcase
            end
            3'd7: begin
                unique case (off)
                    2'd0: ld_data = rd;
                    2'd1: ld_data = {rt_r[31:24], rd[31:8]};
                    2'd2: ld_data = {rt_r[31:16], rd[31:16]};
                    default: ld_data = {rt_r[31:8], rd[31:24]};
                endcase
            end
`endif
            default: ld_data = rd;
        endcase
    end

    assign msbus_o = {ms_to_ws_valid & ~flush_i, pl_r[125:32], ld_data};

    assign fwd_we = ms_valid_r && pl_r.dest[6:5] == 2'b00 &&
                    pl_r.exc == 6'd0 && !flush_i;

    assign msfwd_o = {fwd_we, pl_r.dest[4:0], msbus_o[31:0]};

endmodule

// File: tb/tb_vie_mem_stage.sv
// Bench for vie_mem_stage: vector table with scoreboard plus corner sequences.
// Works with or without VIE_MS_LWLR_EN.
module tb_vie_mem_stage;

    logic         clock;
    logic         reset;
    logic [31:0]  data_sram_rdata;
    logic         ws_allowin;
    logic         flush_i;
    logic [126:0] msbus_o;
    logic [37:0]  msfwd_o;

    vie_mem_stage_if esif ();

    vie_mem_stage dut (
        .clock           (clock),
        .reset           (reset),
        .es              (esif),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .flush_i         (flush_i),
        .msbus_o         (msbus_o),
        .msfwd_o         (msfwd_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  ld;
        logic [31:0] res;
        logic [31:0] rd;
        logic [6:0]  dest;
        logic [5:0]  exc;
        logic [31:0] rt;
        logic [31:0] exp;
        logic        we;
    } vec_t;

    typedef struct {
        logic [126:0] bus;
        logic [37:0]  fwd;
    } exp_t;

    localparam int NV = 15;
    vec_t v[NV];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] ld, input logic [31:0] res,
                                 input logic [31:0] rd, input logic [6:0] dest,
                                 input logic [5:0] exc, input logic [31:0] rt,
                                 input logic [31:0] exp, input logic we);
        vec_t x;
        x.ld = ld; x.res = res; x.rd = rd; x.dest = dest;
        x.exc = exc; x.rt = rt; x.exp = exp; x.we = we;
        return x;
    endfunction

    function automatic logic [125:0] mkpl(input int i, input vec_t x);
        logic [31:0] idx;
        idx = i;
        return {32'h1111_0000 + idx, idx[0], idx[7:0], ~idx[7:0],
                x.exc, x.dest, 32'hBFC0_0000 + (idx << 2), x.res};
    endfunction

    task automatic drive(input int i, input vec_t x);
        esif.esbus_i        = {1'b1, x.ld, mkpl(i, x)};
        esif.es_to_ms_valid = 1'b1;
`ifdef VIE_MS_LWLR_EN
        esif.es_rt_value    = x.rt;
`endif
    endtask

    function automatic exp_t mkexp(input int i, input vec_t x);
        exp_t e;
        logic [125:0] pl;
        pl    = mkpl(i, x);
        e.bus = {1'b1, pl[125:32], x.exp};
        e.fwd = {x.we, x.dest[4:0], x.exp};
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (mon_en && msbus_o[126]) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("sb_empty", 128'(msbus_o), 128'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_msbus", 128'(msbus_o), 128'(e.bus));
                chk("sb_msfwd", 128'(msfwd_o), 128'(e.fwd));
            end
        end
    end

    initial begin
        vec_t x;
        v[0]  = mkv(3'd1, 32'h1003, 32'h80AA5512, 7'd3,  6'd0, 32'd0, 32'hFFFFFF80, 1'b1);
        v[1]  = mkv(3'd2, 32'h1003, 32'h80AA5512, 7'd4,  6'd0, 32'd0, 32'h00000080, 1'b1);
        v[2]  = mkv(3'd4, 32'h1002, 32'h80AA5512, 7'd5,  6'd0, 32'd0, 32'h000080AA, 1'b1);
        v[3]  = mkv(3'd3, 32'h1002, 32'h80AA5512, 7'd6,  6'd0, 32'd0, 32'hFFFF80AA, 1'b1);
        v[4]  = mkv(3'd3, 32'h1000, 32'h80AA5512, 7'd7,  6'd0, 32'd0, 32'h00005512, 1'b1);
        v[5]  = mkv(3'd1, 32'h1001, 32'h80AA5512, 7'd8,  6'd0, 32'd0, 32'h00000055, 1'b1);
        v[6]  = mkv(3'd5, 32'h1000, 32'h80AA5512, 7'h40, 6'd0, 32'd0, 32'h80AA5512, 1'b0);
        v[7]  = mkv(3'd0, 32'h0055, 32'hFFFFFFFF, 7'd9,  6'd0, 32'd0, 32'h00000055, 1'b1);
        v[8]  = mkv(3'd0, 32'h0055, 32'h00000000, 7'd9,  6'h08, 32'd0, 32'h00000055, 1'b0);
        v[9]  = mkv(3'd2, 32'h1002, 32'h12345678, 7'd10, 6'd0, 32'd0, 32'h00000034, 1'b1);
        v[10] = mkv(3'd0, 32'h0077, 32'h00000000, 7'd0,  6'd0, 32'd0, 32'h00000077, 1'b1);
`ifdef VIE_MS_LWLR_EN
        v[11] = mkv(3'd6, 32'h1001, 32'h11223344, 7'd11, 6'd0, 32'hAABBCCDD, 32'h3344CCDD, 1'b1);
        v[12] = mkv(3'd7, 32'h1002, 32'h11223344, 7'd12, 6'd0, 32'hAABBCCDD, 32'hAABB1122, 1'b1);
`else
        v[11] = mkv(3'd6, 32'h1001, 32'h11223344, 7'd11, 6'd0, 32'hAABBCCDD, 32'h11223344, 1'b1);
        v[12] = mkv(3'd7, 32'h1002, 32'h11223344, 7'd12, 6'd0, 32'hAABBCCDD, 32'h11223344, 1'b1);
`endif
        v[13] = mkv(3'd1, 32'h1002, 32'h80AA5512, 7'd13, 6'h04, 32'd0, 32'hFFFFFFAA, 1'b0);
        v[14] = mkv(3'd4, 32'h1003, 32'h80AA5512, 7'd14, 6'd0, 32'd0, 32'h000080AA, 1'b1);

        reset               = 1'b0;
        esif.esbus_i        = '0;
        esif.es_to_ms_valid = 1'b0;
`ifdef VIE_MS_LWLR_EN
        esif.es_rt_value    = 32'd0;
`endif
        data_sram_rdata     = 32'd0;
        ws_allowin          = 1'b1;
        flush_i             = 1'b0;

        #3;
        chk("rst_msbus", 128'(msbus_o), 128'd0);
        chk("rst_msfwd", 128'(msfwd_o), 128'd0);
        chk("rst_allowin", 128'(esif.ms_allowin), 128'd1);
        tick();
        reset = 1'b1;
        tick();

        // table run: back-to-back, no stalls
        mon_en = 1'b1;
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) data_sram_rdata = v[i-1].rd;
            if (i < NV) begin
                drive(i, v[i]);
                sb.push_back(mkexp(i, v[i]));
            end else begin
                esif.es_to_ms_valid = 1'b0;
            end
            tick();
        end
        @(negedge clock);
        mon_en = 1'b0;
        chk("sb_drained", 128'(sb.size()), 128'd0);

        // asynchronous reset mid-stream
        tick();
        x = mkv(3'd0, 32'h0123, 32'd0, 7'd2, 6'd0, 32'd0, 32'h0123, 1'b1);
        drive(50, x);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_msbus", 128'(msbus_o), 128'd0);
        chk("arst_msfwd", 128'(msfwd_o), 128'd0);
        chk("arst_allowin", 128'(esif.ms_allowin), 128'd1);
        tick();
        reset = 1'b1;
        tick();
        esif.es_to_ms_valid = 1'b0;
        chk("arst_after_vld", 128'(msbus_o[126]), 128'd1);
        chk("arst_after_res", 128'(msbus_o[31:0]), 128'h0123);

        // LW stalled for three cycles; SRAM output changes after the first
        tick();
        x = mkv(3'd5, 32'h2000, 32'd0, 7'd13, 6'd0, 32'd0, 32'd0, 1'b1);
        drive(60, x);
        tick();
        esif.es_to_ms_valid = 1'b0;
        data_sram_rdata     = 32'h12345678;
        ws_allowin          = 1'b0;
        @(negedge clock);
        chk("stall_c1", 128'(msbus_o[31:0]), 128'h12345678);
        chk("stall_allowin", 128'(esif.ms_allowin), 128'd0);
        tick();
        data_sram_rdata = 32'hDEADBEEF;
        @(negedge clock);
        chk("stall_c2", 128'(msbus_o[31:0]), 128'h12345678);
        chk("stall_c2_fwd", 128'(msfwd_o), 128'({1'b1, 5'd13, 32'h12345678}));
        tick();
        @(negedge clock);
        chk("stall_c3", 128'(msbus_o[31:0]), 128'h12345678);
        chk("stall_c3_vld", 128'(msbus_o[126]), 128'd1);
        tick();
        ws_allowin = 1'b1;
        @(negedge clock);
        chk("stall_leave", 128'(msbus_o[31:0]), 128'h12345678);
        tick();
        @(negedge clock);
        chk("stall_gone", 128'(msbus_o[126]), 128'd0);
        tick();
        drive(61, x);
        tick();
        esif.es_to_ms_valid = 1'b0;
        data_sram_rdata     = 32'hCAFEF00D;
        @(negedge clock);
        chk("buf_cleared", 128'(msbus_o[31:0]), 128'hCAFEF00D);

        // flush with an instruction in MEM and a new handshake
        tick();
        x = mkv(3'd0, 32'h0099, 32'd0, 7'd14, 6'd0, 32'd0, 32'd0, 1'b1);
        drive(70, x);
        tick();
        x = mkv(3'd0, 32'h00AA, 32'd0, 7'd15, 6'd0, 32'd0, 32'd0, 1'b1);
        drive(71, x);
        flush_i = 1'b1;
        @(negedge clock);
        chk("flush_vld", 128'(msbus_o[126]), 128'd0);
        chk("flush_we", 128'(msfwd_o[37]), 128'd0);
        tick();
        flush_i             = 1'b0;
        esif.es_to_ms_valid = 1'b0;
        @(negedge clock);
        chk("flush_next_vld", 128'(msbus_o[126]), 128'd0);
        chk("flush_next_we", 128'(msfwd_o[37]), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
